// File: rtl/execute_stage_mc.sv
// EX stage: forwarding/ALU-src/RegDst muxes, ALU, EX/MEM register, optional W-cycle shift-add multiplier.
// Build option: define EXEC_MUL_EN to include the multiplier FSM; otherwise busy=0 and mul_e is ignored.
module execute_stage_mc #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_SEL_WIDTH  = 2,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_e,
    input  logic [DATA_WIDTH-1:0]     rd1_e,
    input  logic [DATA_WIDTH-1:0]     rd2_e,
    input  logic [DATA_WIDTH-1:0]     result_w,
    input  logic [DATA_WIDTH-1:0]     alu_out_m,
    input  logic [DATA_WIDTH-1:0]     sign_ext_e,
    input  logic [REG_ADDR_WIDTH-1:0] rt_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic                      alu_src_e,
    input  logic                      reg_dst_e,
    input  logic                      reg_write_e,
    input  logic                      mul_e,
    input  logic [FWD_SEL_WIDTH-1:0]  fwd_a_e,
    input  logic [FWD_SEL_WIDTH-1:0]  fwd_b_e,
    input  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_e,
    output logic                      busy,
    output logic                      valid_m,
    output logic                      reg_write_m,
    output logic [DATA_WIDTH-1:0]     alu_result_m,
    output logic [DATA_WIDTH-1:0]     write_data_m,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_m
);
    localparam logic [FWD_SEL_WIDTH-1:0]  FWD_REG = FWD_SEL_WIDTH'(0);
    localparam logic [FWD_SEL_WIDTH-1:0]  FWD_WB  = FWD_SEL_WIDTH'(1);
    localparam logic [FWD_SEL_WIDTH-1:0]  FWD_MEM = FWD_SEL_WIDTH'(2);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(0);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(1);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(2);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR = ALU_CTRL_WIDTH'(3);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_NOR = ALU_CTRL_WIDTH'(4);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(6);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(7);

    logic [DATA_WIDTH-1:0]     src_a, src_b, write_data, alu_res;
    logic [REG_ADDR_WIDTH-1:0] dest;

    always_comb begin
        case (fwd_a_e)
            FWD_REG: src_a = rd1_e;
            FWD_WB:  src_a = result_w;
            FWD_MEM: src_a = alu_out_m;
            default: src_a = '0;
        endcase
        case (fwd_b_e)
            FWD_REG: write_data = rd2_e;
            FWD_WB:  write_data = result_w;
            FWD_MEM: write_data = alu_out_m;
            default: write_data = '0;
        endcase
        src_b = alu_src_e ? sign_ext_e : write_data;
        dest  = reg_dst_e ? rd_e : rt_e;
    end

    always_comb begin
        case (alu_ctrl_e)
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_ADD: alu_res = src_a + src_b;
            ALU_XOR: alu_res = src_a ^ src_b;
            ALU_NOR: alu_res = ~(src_a | src_b);
            ALU_SUB: alu_res = src_a - src_b;
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = '0;
        endcase
    end

    logic                      valid_m_q, valid_m_d;
    logic                      reg_write_m_q, reg_write_m_d;
    logic [DATA_WIDTH-1:0]     alu_result_m_q, alu_result_m_d;
    logic [DATA_WIDTH-1:0]     write_data_m_q, write_data_m_d;
    logic [REG_ADDR_WIDTH-1:0] write_reg_m_q, write_reg_m_d;

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic [DATA_WIDTH-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] mul_dst_q, mul_dst_d;
    logic                      mul_rw_q, mul_rw_d;
    logic [DATA_WIDTH-1:0]     acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        mul_dst_d      = mul_dst_q;
        mul_rw_d       = mul_rw_q;
        valid_m_d      = 1'b0;
        reg_write_m_d  = 1'b0;
        alu_result_m_d = '0;
        write_data_m_d = '0;
        write_reg_m_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (valid_e && mul_e) begin
                    state_d   = S_MUL;
                    busy_d    = 1'b1;
                    mcand_d   = src_a;
                    mplier_d  = src_b;
                    acc_d     = '0;
                    cnt_d     = '0;
                    mul_dst_d = dest;
                    mul_rw_d  = reg_write_e;
                end else if (valid_e) begin
                    valid_m_d      = 1'b1;
                    reg_write_m_d  = reg_write_e;
                    alu_result_m_d = alu_res;
                    write_data_m_d = write_data;
                    write_reg_m_d  = dest;
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Final iteration writes the product straight into EX/MEM.
                if (cnt_q == CNT_LAST) begin
                    state_d        = S_IDLE;
                    busy_d         = 1'b0;
                    valid_m_d      = 1'b1;
                    reg_write_m_d  = mul_rw_q;
                    alu_result_m_d = acc_next;
                    write_reg_m_d  = mul_dst_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mul_dst_q <= '0;
            mul_rw_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mul_dst_q <= mul_dst_d;
            mul_rw_q  <= mul_rw_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_mul;
    assign unused_mul = mul_e;

    always_comb begin
        valid_m_d      = valid_e;
        reg_write_m_d  = valid_e & reg_write_e;
        alu_result_m_d = valid_e ? alu_res    : '0;
        write_data_m_d = valid_e ? write_data : '0;
        write_reg_m_d  = valid_e ? dest       : '0;
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_m_q      <= 1'b0;
            reg_write_m_q  <= 1'b0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            write_reg_m_q  <= '0;
        end else begin
            valid_m_q      <= valid_m_d;
            reg_write_m_q  <= reg_write_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            write_reg_m_q  <= write_reg_m_d;
        end
    end

    assign valid_m      = valid_m_q;
    assign reg_write_m  = reg_write_m_q;
    assign alu_result_m = alu_result_m_q;
    assign write_data_m = write_data_m_q;
    assign write_reg_m  = write_reg_m_q;
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc (W=32); multiplier steps run when EXEC_MUL_EN is defined.
module tb_execute_stage_mc;
    logic        clk = 1'b0;
    logic        rst, valid_e, alu_src_e, reg_dst_e, reg_write_e, mul_e;
    logic [31:0] rd1_e, rd2_e, result_w, alu_out_m, sign_ext_e;
    logic [4:0]  rt_e, rd_e;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [2:0]  alu_ctrl_e;
    logic        busy, valid_m, reg_write_m;
    logic [31:0] alu_result_m, write_data_m;
    logic [4:0]  write_reg_m;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    execute_stage_mc dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .result_w(result_w), .alu_out_m(alu_out_m), .sign_ext_e(sign_ext_e),
        .rt_e(rt_e), .rd_e(rd_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
        .reg_write_e(reg_write_e), .mul_e(mul_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .alu_ctrl_e(alu_ctrl_e), .busy(busy), .valid_m(valid_m), .reg_write_m(reg_write_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .write_reg_m(write_reg_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl);
        valid_e = 1'b1; mul_e = 1'b0; rd1_e = a; rd2_e = b; alu_ctrl_e = ctrl;
        fwd_a_e = 2'd0; fwd_b_e = 2'd0; alu_src_e = 1'b0;
        reg_dst_e = 1'b1; rd_e = 5'd9; rt_e = 5'd3; reg_write_e = 1'b1;
    endtask

`ifdef EXEC_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod, input string tag);
        set_op(a, b, 3'b010);
        mul_e = 1'b1; rd_e = 5'd12;
        tick();
        check({tag, "_busy_1"}, {31'd0, busy}, 32'd1);
        check({tag, "_vld_1"}, {31'd0, valid_m}, 32'd0);
        // Upstream advances past the MUL: next instruction is an ADD 1+2 held behind it.
        set_op(32'd1, 32'd2, 3'b010);
        for (int i = 2; i <= 32; i++) begin
            tick();
            check({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
            check({tag, "_vld_hold"}, {31'd0, valid_m}, 32'd0);
        end
        tick();
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_vld_done"}, {31'd0, valid_m}, 32'd1);
        check({tag, "_prod"}, alu_result_m, prod);
        check({tag, "_wdata"}, write_data_m, 32'd0);
        check({tag, "_wreg"}, {27'd0, write_reg_m}, 32'd12);
        check({tag, "_rw"}, {31'd0, reg_write_m}, 32'd1);
        tick();
        check({tag, "_held_add"}, alu_result_m, 32'd3);
        check({tag, "_held_vld"}, {31'd0, valid_m}, 32'd1);
    endtask
`endif

    initial begin
        rst = 1'b1; valid_e = 1'b0; mul_e = 1'b0; alu_src_e = 1'b0; reg_dst_e = 1'b0;
        reg_write_e = 1'b0; rd1_e = '0; rd2_e = '0; result_w = '0; alu_out_m = '0;
        sign_ext_e = '0; rt_e = '0; rd_e = '0; fwd_a_e = '0; fwd_b_e = '0; alu_ctrl_e = '0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid_m}, 32'd0);
        check("rst_result", alu_result_m, 32'd0);
        check("rst_wreg", {27'd0, write_reg_m}, 32'd0);
        rst = 1'b0;

        set_op(32'd5, 32'd7, 3'b010); tick();
        check("add_res", alu_result_m, 32'd12);
        check("add_wreg", {27'd0, write_reg_m}, 32'd9);
        check("add_vld", {31'd0, valid_m}, 32'd1);
        check("add_rw", {31'd0, reg_write_m}, 32'd1);
        check("add_wdata", write_data_m, 32'd7);

        set_op(32'd0, 32'd0, 3'b010);
        fwd_a_e = 2'd2; alu_out_m = 32'd100; alu_src_e = 1'b1; sign_ext_e = 32'hFFFF_FFFC;
        fwd_b_e = 2'd1; result_w = 32'h55; reg_dst_e = 1'b0; reg_write_e = 1'b0; tick();
        check("fwd_imm_res", alu_result_m, 32'd96);
        check("fwd_wdata", write_data_m, 32'h55);
        check("fwd_rt", {27'd0, write_reg_m}, 32'd3);
        check("fwd_rw", {31'd0, reg_write_m}, 32'd0);

        set_op(32'hFFFF_FFFF, 32'd1, 3'b111); tick(); check("slt", alu_result_m, 32'd1);
        set_op(32'hFFFF_FFFF, 32'd1, 3'b110); tick(); check("sub", alu_result_m, 32'hFFFF_FFFE);
        set_op(32'h7FFF_FFFF, 32'd1, 3'b010); tick(); check("add_ovf", alu_result_m, 32'h8000_0000);
        set_op(32'd1, 32'hFFFF_FFFF, 3'b111); tick(); check("slt_false", alu_result_m, 32'd0);
        set_op(32'h0000_F0F0, 32'h0000_FF00, 3'b000); tick(); check("and", alu_result_m, 32'h0000_F000);
        set_op(32'h0000_F0F0, 32'h0000_FF00, 3'b001); tick(); check("or", alu_result_m, 32'h0000_FFF0);
        set_op(32'h0000_F0F0, 32'h0000_FF00, 3'b011); tick(); check("xor", alu_result_m, 32'h0000_0FF0);
        set_op(32'h0000_F0F0, 32'h0000_FF00, 3'b100); tick(); check("nor", alu_result_m, 32'hFFFF_000F);
        set_op(32'h0000_F0F0, 32'h0000_FF00, 3'b101); tick(); check("op101", alu_result_m, 32'd0);
        set_op(32'd77, 32'd8, 3'b010); fwd_a_e = 2'd3; fwd_b_e = 2'd3; tick();
        check("fwd_zero", alu_result_m, 32'd0);

        set_op(32'd5, 32'd7, 3'b010); valid_e = 1'b0; tick();
        check("bubble_vld", {31'd0, valid_m}, 32'd0);
        check("bubble_res", alu_result_m, 32'd0);
        check("bubble_rw", {31'd0, reg_write_m}, 32'd0);

`ifdef EXEC_MUL_EN
        run_mul(32'd3, 32'd7, 32'd21, "mul3x7");
        run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mulneg");

        set_op(32'd4, 32'd5, 3'b010); mul_e = 1'b1; tick();
        set_op(32'd0, 32'd0, 3'b010);
        for (int i = 2; i <= 10; i++) tick();
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_vld", {31'd0, valid_m}, 32'd0);
        check("abort_res", alu_result_m, 32'd0);
        check("abort_wreg", {27'd0, write_reg_m}, 32'd0);
        set_op(32'd1, 32'd1, 3'b010); tick();
        check("post_abort_add", alu_result_m, 32'd2);
        check("post_abort_vld", {31'd0, valid_m}, 32'd1);
        valid_e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("no_late_prod", {31'd0, valid_m}, 32'd0);
        end
`else
        set_op(32'd3, 32'd7, 3'b010); mul_e = 1'b1; tick();
        check("nomul_busy", {31'd0, busy}, 32'd0);
        check("nomul_res", alu_result_m, 32'd10);
        check("nomul_vld", {31'd0, valid_m}, 32'd1);
        tick();
        check("nomul_busy2", {31'd0, busy}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
